// File: rtl/edge_synchronizer.sv
// -----------------------------------------------------------------------------
// edge_synchronizer
//
// Brings WIDTH independent single-bit asynchronous channels into the clock
// domain through a STAGES-deep flop chain per channel. Each channel yields a
// synchronized level plus one-cycle rising/falling edge pulses. Not intended
// for coherent multi-bit buses: channels may resolve on different cycles.
//
// Optional stability filter: define EDGE_SYNCHRONIZER_FILTER_EN. Each channel
// then has a small counter, and data_out follows the synchronized level only
// after it has differed from data_out for FILTER_CYCLES consecutive cycles.
// Without the macro, FILTER_CYCLES is ignored and data_out is the last stage.
//
// Parameters:
//   WIDTH          number of independent channels (>=1)
//   STAGES         synchronizer flops per channel (>=1)
//   RESET_VALUE    reset level of every stage, data_out and history register
//   FILTER_CYCLES  stable cycles required before data_out changes (>=1)
//
// Ports:
//   clock         in   destination clock, rising edge
//   reset         in   synchronous, active-high reset
//   data_in       in   [WIDTH] asynchronous channel inputs
//   data_out      out  [WIDTH] synchronized (optionally filtered) level
//   rising_edge   out  [WIDTH] one-cycle pulse on data_out 0->1
//   falling_edge  out  [WIDTH] one-cycle pulse on data_out 1->0
//
// No handshakes: every output is valid every cycle.
// -----------------------------------------------------------------------------
module edge_synchronizer #(
  parameter int               WIDTH         = 1,
  parameter int               STAGES        = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0,
  parameter int               FILTER_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] rising_edge,
  output logic [WIDTH-1:0] falling_edge
);

  // Elaboration-time sanity check on the configuration.
  if (WIDTH < 1 || STAGES < 1 || FILTER_CYCLES < 1) begin : g_bad_params
    $error("edge_synchronizer: WIDTH, STAGES and FILTER_CYCLES must be >= 1");
  end

  // stage_q[0] captures the asynchronous input; stage_q[STAGES-1] is the
  // synchronized level.
  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] previous_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= RESET_VALUE;
      end
    end else begin
      stage_q[0] <= data_in;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign sync = stage_q[STAGES-1];

`ifdef EDGE_SYNCHRONIZER_FILTER_EN
  localparam int CW = $clog2(FILTER_CYCLES + 1);

  logic [CW-1:0]    count_q [WIDTH];
  logic [WIDTH-1:0] filtered_q;

  // Per channel: count consecutive cycles where sync disagrees with the
  // output. Any agreement restarts the count; reaching FILTER_CYCLES-1 with
  // a still-differing input commits the new level and clears the counter,
  // so the counter never saturates or wraps.
  always_ff @(posedge clock) begin
    if (reset) begin
      filtered_q <= RESET_VALUE;
      for (int i = 0; i < WIDTH; i++) begin
        count_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync[i] == filtered_q[i]) begin
          count_q[i] <= '0;
        end else if (count_q[i] == CW'(FILTER_CYCLES - 1)) begin
          filtered_q[i] <= sync[i];
          count_q[i]    <= '0;
        end else begin
          count_q[i] <= count_q[i] + CW'(1);
        end
      end
    end
  end

  assign data_out = filtered_q;
`else
  // Last chain stage is already a register, so data_out has no
  // combinational path from data_in.
  assign data_out = sync;
`endif

  // History register for edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      previous_q <= RESET_VALUE;
    end else begin
      previous_q <= data_out;
    end
  end

  // Pulses are forced low while reset is asserted, before the reset edge
  // has cleared the history register.
  assign rising_edge  = data_out & ~previous_q & ~{WIDTH{reset}};
  assign falling_edge = ~data_out & previous_q & ~{WIDTH{reset}};

endmodule

// File: tb/tb_edge_synchronizer.sv
// -----------------------------------------------------------------------------
// tb_edge_synchronizer
//
// Five instances (STAGES = 1..5, WIDTH = 4, RESET_VALUE = 0,
// FILTER_CYCLES = 3) share one data_in. Inputs change at 25% of the period,
// outputs are sampled at 75%. Expected values come from a latency model:
// a clean step first seen at edge 1 appears on data_out after edge
// STAGES (+FILTER_CYCLES with the filter), with a pulse in exactly that cycle.
// -----------------------------------------------------------------------------
module tb_edge_synchronizer;

`ifdef EDGE_SYNCHRONIZER_FILTER_EN
  localparam int FLT = 3;
`else
  localparam int FLT = 0;
`endif
  localparam int NSTEP = 5 + FLT + 2;

  // Clock / reset
  logic clock;
  logic reset;
  logic [3:0] data_in;
  logic [3:0] cur;

  initial clock = 1'b0;
  always #10 clock = ~clock;

  logic [3:0] dout [1:5];
  logic [3:0] rise [1:5];
  logic [3:0] fall [1:5];

  genvar g;
  for (g = 1; g <= 5; g++) begin : g_dut
    edge_synchronizer #(
      .WIDTH(4),
      .STAGES(g),
      .RESET_VALUE(4'h0),
      .FILTER_CYCLES(3)
    ) u_dut (
      .clock(clock),
      .reset(reset),
      .data_in(data_in),
      .data_out(dout[g]),
      .rising_edge(rise[g]),
      .falling_edge(fall[g])
    );
  end

  // Scoreboard counters
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected outputs k edges after a step ov->nv was first presented.
  task automatic check_all(input logic [3:0] ov, input logic [3:0] nv,
                           input int k, input string name);
    int lat;
    logic [3:0] eo, er, ef;
    for (int s = 1; s <= 5; s++) begin
      lat = s + FLT;
      eo  = (k >= lat) ? nv : ov;
      er  = (k == lat) ? (nv & ~ov) : 4'h0;
      ef  = (k == lat) ? (~nv & ov) : 4'h0;
      check($sformatf("%s_s%0d_k%0d_out",  name, s, k), dout[s], eo);
      check($sformatf("%s_s%0d_k%0d_rise", name, s, k), rise[s], er);
      check($sformatf("%s_s%0d_k%0d_fall", name, s, k), fall[s], ef);
    end
  endtask

  task automatic check_reset(input string name);
    for (int s = 1; s <= 5; s++) begin
      check($sformatf("%s_s%0d_out",  name, s), dout[s], 4'h0);
      check($sformatf("%s_s%0d_rise", name, s), rise[s], 4'h0);
      check($sformatf("%s_s%0d_fall", name, s), fall[s], 4'h0);
    end
  endtask

  // Driver tasks
  task automatic drive_point();
    @(posedge clock);
    #5;
  endtask

  task automatic sample_point();
    @(posedge clock);
    #15;
  endtask

  task automatic apply_step(input logic [3:0] nv, input string name);
    logic [3:0] ov;
    ov = cur;
    drive_point();
    data_in = nv;
    cur     = nv;
    for (int k = 1; k <= NSTEP; k++) begin
      sample_point();
      check_all(ov, nv, k, name);
    end
  endtask

  initial begin
    reset   = 1'b1;
    data_in = 4'h0;
    cur     = 4'h0;

    // Power-on reset
    repeat (2) @(posedge clock);
    sample_point();
    check_reset("init");
    drive_point();
    reset = 1'b0;
    for (int k = 1; k <= NSTEP; k++) begin
      sample_point();
      check_all(4'h0, 4'h0, k, "idle");
    end

    // Clean steps, including simultaneous rise/fall on different bits
    apply_step(4'h5, "s0to5");
    apply_step(4'h0, "s5to0");
    apply_step(4'hA, "s0toA");
    apply_step(4'h3, "sAto3");
    apply_step(4'hC, "s3toC");
    apply_step(4'h0, "sCto0");

    // Reset in the middle of propagation, input held at 0xF
    drive_point();
    data_in = 4'hF;
    cur     = 4'hF;
    @(posedge clock);
    drive_point();
    reset = 1'b1;
    sample_point();
    check_reset("rst_a");
    sample_point();
    check_reset("rst_b");
    drive_point();
    reset = 1'b0;
    for (int k = 1; k <= NSTEP; k++) begin
      sample_point();
      check_all(4'h0, 4'hF, k, "rel");
    end

`ifdef EDGE_SYNCHRONIZER_FILTER_EN
    apply_step(4'h0, "f_to0");

    // bit0 high for only 2 cycles: filtered away
    for (int j = 0; j < 12; j++) begin
      @(posedge clock);
      #5;
      data_in = (j < 2) ? 4'h1 : 4'h0;
      #10;
      check_all(4'h0, 4'h1, -100, "f_glitch");
    end
    cur = 4'h0;

    // Held long enough: single rising pulse after STAGES+3 edges
    apply_step(4'h1, "f_held");
    apply_step(4'h0, "f_back0");

    // 2 high, 1 low, then held high: count restarts at the 4th drive
    for (int j = 0; j < 14; j++) begin
      @(posedge clock);
      #5;
      data_in = (j == 2) ? 4'h0 : 4'h1;
      #10;
      check_all(4'h0, 4'h1, j - 3, "f_gap");
    end
    cur = 4'h1;
`endif

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
